vram_scanout: RTL

VRAM_SCANOUT -- requirements
Module: vram_scanout

---
 rtl/vram_scanout.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vram_scanout.sv
// vram_scanout: 1bpp framebuffer scan-out with integer horizontal/vertical pixel scaling
//
// Ports:
//   render_clk               clock; all state updates on its rising edge
//   rst                      asynchronous active-high reset
//   frame_start              one-cycle pulse in vertical blanking; rewinds to row 0
//   de_in/hsync_in/vsync_in  timing-generator data enable and syncs
//   render_data[7:0]         VRAM read data, valid one cycle after render_addr
//   render_addr[14:0]        registered address of the next byte to display
//   pix_out                  registered pixel, 1-cycle latency from de_in
//   de_out/hsync_out/vsync_out  timing inputs delayed by one cycle
//
// Optional feature (macro SCANOUT_INVERT_EN): adds input invert; the pixel is
// XORed with invert while the delayed data enable is high.
module vram_scanout #(
    parameter int H_SCALE       = 3,
    parameter int V_SCALE       = 3,
    parameter int BYTES_PER_ROW = 60,
    parameter int ROWS          = 300
) (
    input  logic        render_clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
`ifdef SCANOUT_INVERT_EN
    input  logic        invert,
`endif
    input  logic [7:0]  render_data,
    output logic [14:0] render_addr,
    output logic        pix_out,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out
);
    localparam int HW = H_SCALE > 1 ? $clog2(H_SCALE) : 1;
    localparam int VW = V_SCALE > 1 ? $clog2(V_SCALE) : 1;
    localparam int RW = $clog2(ROWS + 1);
    localparam int LW = $clog2(BYTES_PER_ROW + 1);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [LW-1:0] loads_q, loads_d;
    logic [VW-1:0] rep_q, rep_d;
    logic [RW-1:0] row_q, row_d;
    logic [14:0]   base_q, base_d;
    logic [14:0]   addr_q, addr_d;
    logic          armed_q, armed_d;
    logic          pix_q, pix_d;
    logic          de_q, hs_q, vs_q;
    logic          busy, active, load, last_h, de_fall, rep_wrap, pix_c;
    logic [7:0]    cur;

    // busy: a byte is mid-display (hcnt/bit counters away from their start).
    // active: a frame has been started since reset and rows remain.
    always_comb begin
        busy     = (hcnt_q != '0) || (bit_q != '0);
        active   = armed_q && (row_q < RW'(ROWS));
        load     = de_in && active && !busy && (loads_q < LW'(BYTES_PER_ROW));
        cur      = load ? render_data : shift_q;
        pix_c    = de_in && (load || busy) && cur[7];
        last_h   = hcnt_q == HW'(H_SCALE - 1);
        de_fall  = de_q && !de_in;
        rep_wrap = rep_q == VW'(V_SCALE - 1);
        hcnt_d   = !de_in ? '0 : (load || busy) ? (last_h ? '0 : hcnt_q + HW'(1)) : hcnt_q;
        bit_d    = !de_in ? '0 : ((load || busy) && last_h) ? bit_q + 3'd1 : bit_q;
        shift_d  = !de_in ? shift_q : (load || busy) ? (last_h ? {cur[6:0], 1'b0} : cur) : shift_q;
        loads_d  = !de_in ? '0 : loads_q + LW'(load);
        armed_d  = armed_q || frame_start;
        rep_d    = rep_q;
        row_d    = row_q;
        base_d   = base_q;
        addr_d   = addr_q;
        if (frame_start) begin
            rep_d  = '0;
            row_d  = '0;
            base_d = '0;
            addr_d = '0;
        end else if (de_fall && active) begin
            rep_d  = rep_wrap ? '0 : rep_q + VW'(1);
            row_d  = rep_wrap ? row_q + RW'(1) : row_q;
            // Leaving the last row parks the address at 0 for the rest of the frame.
            base_d = !rep_wrap ? base_q : (row_q == RW'(ROWS - 1)) ? '0 : base_q + 15'(BYTES_PER_ROW);
            addr_d = base_d;
        end else if (load) begin
            addr_d = addr_q + 15'd1;
        end
`ifdef SCANOUT_INVERT_EN
        pix_d = pix_c ^ (invert & de_in);
`else
        pix_d = pix_c;
`endif
    end

    always_ff @(posedge render_clk or posedge rst) begin
        if (rst) begin
            hcnt_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            loads_q <= '0;
            rep_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            armed_q <= 1'b0;
            pix_q   <= 1'b0;
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            loads_q <= loads_d;
            rep_q   <= rep_d;
            row_q   <= row_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            armed_q <= armed_d;
            pix_q   <= pix_d;
            de_q    <= de_in;
            hs_q    <= hsync_in;
            vs_q    <= vsync_in;
        end
    end

    assign render_addr = addr_q;
    assign pix_out     = pix_q;
    assign de_out      = de_q;
    assign hsync_out   = hs_q;
    assign vsync_out   = vs_q;
endmodule
